// File: rtl/tff_step_ctrl.sv
// tff_step_ctrl: step controller for a bank of T flip-flops forming a counter
// that wraps at MAX_COUNT.
// A noisy push-button is synchronised and debounced. A press gives one step.
// A long hold gives auto-repeat: the second step comes after REPEAT_DELAY
// cycles, then one step every REPEAT_PERIOD cycles. For each step, the block
// drives registered per-bit toggle enables that move the bank to the next
// up/down count.
//
// Ports:
//   CLK50M  in   system clock; all logic runs on its rising edge
//   RST_N   in   synchronous reset, active-low
//   BUTTON  in   raw asynchronous push-button, active-high
//   UP      in   1 = count up, 0 = count down
//   EN      in   step enable; 0 drops steps (CLEAR still honoured)
//   CLEAR   in   one-cycle request to force the bank to 0
//   Q_IN    in   current Q of the T flip-flop bank
//   T_OUT   out  registered toggle enables to the bank
//   STEP    out  one-cycle pulse, coincident with a non-clear T_OUT update
module tff_step_ctrl #(
    parameter int WIDTH         = 4,
    parameter int MAX_COUNT     = 9,
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             CLK50M,
    input  logic             RST_N,
    input  logic             BUTTON,
    input  logic             UP,
    input  logic             EN,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] T_OUT,
    output logic             STEP
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    DELAY_LD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    PERIOD_LD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic          sync0, btn_s;
    logic [DW-1:0] deb_cnt;
    logic          stable;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic             step_req;
    logic [WIDTH-1:0] next_cnt;

    // Two-flop synchroniser followed by the debouncer. Any sample that matches
    // the accepted level restarts the count, so a level is accepted only after
    // it has been held for DEB_CYCLES consecutive samples.
    always_ff @(posedge CLK50M) begin
        if (!RST_N) begin
            sync0   <= 1'b0;
            btn_s   <= 1'b0;
            deb_cnt <= '0;
            stable  <= 1'b0;
        end else begin
            sync0 <= BUTTON;
            btn_s <= sync0;
            if (btn_s == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stable  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK50M) begin
        if (!RST_N) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // FSM next state. stable can only be 1 in IDLE right after a 0->1
    // change, because IDLE is entered only on reset (stable cleared) or on
    // release (stable == 0). A release also wins over a timer expiry in the
    // same cycle.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (stable) begin
                    state_nxt = HOLD;
                    timer_nxt = DELAY_LD;
                end
            end
            HOLD, REPEAT: begin
                if (!stable) begin
                    state_nxt = IDLE;
                end else if (timer == '0) begin
                    state_nxt = REPEAT;
                    timer_nxt = PERIOD_LD;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the step request and the target count, taken from Q_IN
    // in the request cycle. An out-of-range bank value always recovers to 0.
    always_comb begin
        step_req = 1'b0;
        if (stable && (state == IDLE || timer == '0))
            step_req = 1'b1;

        if (Q_IN > MAX_V)
            next_cnt = '0;
        else if (UP)
            next_cnt = (Q_IN == MAX_V) ? '0 : Q_IN + WIDTH'(1);
        else
            next_cnt = (Q_IN == '0) ? MAX_V : Q_IN - WIDTH'(1);
    end

    // Toggle register. CLEAR toggles every set bit, so the bank goes to 0 and
    // any step request in the same cycle is dropped. T_OUT is nonzero for
    // only one cycle at a time.
    always_ff @(posedge CLK50M) begin
        if (!RST_N) begin
            T_OUT <= '0;
            STEP  <= 1'b0;
        end else if (CLEAR) begin
            T_OUT <= Q_IN;
            STEP  <= 1'b0;
        end else if (step_req && EN) begin
            T_OUT <= Q_IN ^ next_cnt;
            STEP  <= 1'b1;
        end else begin
            T_OUT <= '0;
            STEP  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tff_step_ctrl.sv
// Bench for tff_step_ctrl with a behavioural T flip-flop bank closed on
// Q_IN/T_OUT. Expected toggle patterns are queued when stimulus is driven.
// A negedge monitor pops one pattern per STEP pulse and compares it.
module tb_tff_step_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, button, up, en, clear;
    logic [W-1:0] q_in, t_out;
    logic         step;

    logic [W-1:0] bq;
    logic         ld = 1'b0;
    logic [W-1:0] ld_v = '0;
    int           cyc = 0;
    logic         mon_en = 1'b0;
    logic         clr_win = 1'b0;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           step_cyc[$];
    logic [W-1:0] e;

    tff_step_ctrl #(
        .WIDTH(4), .MAX_COUNT(9), .DEB_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .CLK50M(clk), .RST_N(rst_n), .BUTTON(button), .UP(up), .EN(en),
        .CLEAR(clear), .Q_IN(q_in), .T_OUT(t_out), .STEP(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // T flip-flop bank, with a load port so tests can preset any value
    always @(posedge clk) begin
        if (ld) bq <= ld_v;
        else    bq <= bq ^ t_out;
    end
    assign q_in = bq;

    always @(negedge clk) begin
        if (mon_en) begin
            if (step === 1'b1) begin
                checks++;
                step_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL step_unexpected: got T_OUT=%b at cycle %0d, expected no step", t_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (t_out !== e) begin
                        errors++;
                        $display("FAIL step_t_out: got %b expected %b at cycle %0d", t_out, e, cyc);
                    end
                end
            end else if (!clr_win && t_out !== '0) begin
                errors++;
                $display("FAIL t_out_idle: got %b expected 0000 with STEP=%b at cycle %0d", t_out, step, cyc);
            end
        end
    end

    function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic dir_up);
        if (q > 4'd9)   return 4'd0;
        else if (dir_up) return (q == 4'd9) ? 4'd0 : q + 4'd1;
        else             return (q == 4'd0) ? 4'd9 : q - 4'd1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        ld = 1'b1; ld_v = v;
        tick(1);
        ld = 1'b0;
    endtask

    task automatic press(input int n);
        button = 1'b1;
        tick(n);
        button = 1'b0;
    endtask

    task automatic check_q(input string name, input logic [W-1:0] want);
        checks++;
        if (bq !== want) begin
            errors++;
            $display("FAIL %s: got Q=%0d expected %0d", name, bq, want);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d steps outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; button = 1'b0; up = 1'b1; en = 1'b1; clear = 1'b0;
        ld = 1'b1; ld_v = '0;
        tick(2);
        ld = 1'b0; rst_n = 1'b1;
        checks++;
        if (t_out !== '0 || step !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got T_OUT=%b STEP=%b expected 0000/0", t_out, step);
        end
        mon_en = 1'b1;
        tick(10);
        check_q("reset_q", 4'd0);
    endtask

    task automatic test_single_press;
        up = 1'b1;
        load(4'd0);
        step_cyc.delete();
        exp_q.push_back(4'b0001);
        button = 1'b1; tick(3); button = 1'b0; tick(2);
        button = 1'b1; tick(10);
        button = 1'b0; tick(3); button = 1'b1; tick(2);
        button = 1'b0; tick(30);
        checks++;
        if (step_cyc.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d steps expected 1", step_cyc.size());
        end
        check_q("single_q", 4'd1);
    endtask

    task automatic test_hold_repeat;
        logic [W-1:0] m;
        up = 1'b1;
        load(4'd7);
        step_cyc.delete();
        m = 4'd7;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(m ^ model_next(m, 1'b1));
            m = model_next(m, 1'b1);
        end
        press(58);
        tick(30);
        checks++;
        if (step_cyc.size() != 6) begin
            errors++;
            $display("FAIL hold_count: got %0d steps expected 6", step_cyc.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (step_cyc[i] - step_cyc[i-1] != ((i == 1) ? 20 : 8)) begin
                    errors++;
                    $display("FAIL hold_interval%0d: got %0d expected %0d", i,
                             step_cyc[i] - step_cyc[i-1], (i == 1) ? 20 : 8);
                end
            end
        end
        check_q("hold_q", 4'd3);
    endtask

    task automatic test_down_and_illegal;
        up = 1'b0;
        load(4'd0);
        exp_q.push_back(4'b1001);
        press(10);
        tick(25);
        check_q("down_wrap_q", 4'd9);
        load(4'd12);
        exp_q.push_back(4'b1100);
        press(10);
        tick(25);
        check_q("illegal_q", 4'd0);
    endtask

    task automatic test_clear;
        up = 1'b1;
        load(4'd6);
        button = 1'b1;
        tick(6);
        clear = 1'b1; clr_win = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++;
        if (t_out !== 4'b0110 || step !== 1'b0) begin
            errors++;
            $display("FAIL clear_out: got T_OUT=%b STEP=%b expected 0110/0", t_out, step);
        end
        tick(1);
        clr_win = 1'b0;
        tick(8);
        button = 1'b0;
        tick(25);
        check_q("clear_q", 4'd0);
    endtask

    task automatic test_enable;
        up = 1'b1;
        load(4'd3);
        en = 1'b0;
        button = 1'b1;
        tick(38);
        checks++;
        if (bq !== 4'd3) begin
            errors++;
            $display("FAIL en_masked_q: got %0d expected 3", bq);
        end
        en = 1'b1;
        exp_q.push_back(4'b0111);
        tick(6);
        button = 1'b0;
        tick(30);
        check_q("en_resume_q", 4'd4);
    endtask

    task automatic test_reset_mid_repeat;
        int rc;
        up = 1'b1; en = 1'b1;
        load(4'd0);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0001);
        button = 1'b1;
        tick(38);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rc = cyc;
        checks++;
        if (t_out !== '0 || step !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out: got T_OUT=%b STEP=%b expected 0000/0", t_out, step);
        end
        check_q("rst_mid_pre_q", 4'd3);
        step_cyc.delete();
        exp_q.push_back(4'b0111);
        tick(10);
        button = 1'b0;
        tick(25);
        checks++;
        if (step_cyc.size() != 1 || step_cyc[0] != rc + 7) begin
            errors++;
            $display("FAIL rst_mid_fresh: got %0d steps first at %0d expected 1 at %0d",
                     step_cyc.size(), (step_cyc.size() > 0) ? step_cyc[0] : -1, rc + 7);
        end
        check_q("rst_mid_post_q", 4'd4);
        exp_q.push_back(4'b0001);
        press(10);
        tick(25);
        check_q("rst_mid_after_q", 4'd5);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_down_and_illegal();
        test_clear();
        test_enable();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
